// File: rtl/ice_risc_dbg_pkg.sv
// Shared definitions for the single-step debug controller: FSM states,
// default period constants and counter-width helpers.
package ice_risc_dbg_pkg;

  // Step controller FSM states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FIRST  = 3'd1,
    HOLD   = 3'd2,
    REPEAT = 3'd3,
    RUN    = 3'd4
  } stepState_e;

  // Default periods in 100 MHz clock cycles.
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;    // 10 ms
  localparam int DEF_HOLD_CYCLES     = 50000000;   // 500 ms
  localparam int DEF_REPEAT_CYCLES   = 10000000;   // 100 ms
  localparam int DEF_RATE0           = 100000000;  // 1 Hz
  localparam int DEF_RATE1           = 10000000;   // 10 Hz
  localparam int DEF_RATE2           = 1000000;    // 100 Hz
  localparam int DEF_RATE3           = 100000;     // 1 kHz

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed for a counter that runs 0 .. maxVal-1 (at least one bit).
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 2) ? 1 : $clog2(maxVal);
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizers for the raw key and run inputs, plus a debouncer
// that only moves the key level after it has been contradicted for
// DEBOUNCE_CYCLES consecutive cycles.
module sync_debounce
  import ice_risc_dbg_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic rawKey,
  input  logic rawRun,
  output logic keyLevel,
  output logic runSync
);

  localparam int CW = cntWidth(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          keyMeta;
  logic          keySync;
  logic          runMeta;
  logic [CW-1:0] dbCnt;

  // Metastability guard for both asynchronous inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      keyMeta <= 1'b0;
      keySync <= 1'b0;
      runMeta <= 1'b0;
      runSync <= 1'b0;
    end else begin
      keyMeta <= rawKey;
      keySync <= keyMeta;
      runMeta <= rawRun;
      runSync <= runMeta;
    end
  end

  // Count consecutive disagreeing cycles; any agreeing cycle restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      keyLevel <= 1'b0;
      dbCnt    <= '0;
    end else if (keySync != keyLevel) begin
      if (dbCnt == DB_LAST) begin
        keyLevel <= keySync;
        dbCnt    <= '0;
      end else begin
        dbCnt <= dbCnt + CW'(1);
      end
    end else begin
      dbCnt <= '0;
    end
  end

endmodule

// File: rtl/step_controller.sv
// Single-step / free-run controller for the CPU debug path. Manual mode
// issues one step per debounced key press with auto-repeat while held;
// run mode issues steps at a selectable fixed period.
module step_controller
  import ice_risc_dbg_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int RATE0           = DEF_RATE0,
  parameter int RATE1           = DEF_RATE1,
  parameter int RATE2           = DEF_RATE2,
  parameter int RATE3           = DEF_RATE3
) (
  input  logic        iwClk100M,
  input  logic        iwRst,
  input  logic        iwKey,
  input  logic        iwRun,
  input  logic [1:0]  iwRate,
  output logic        owStepEn,
  output logic        owKeyLevel,
  output logic [15:0] owStepCount
);

  // One counter serves hold, repeat and run periods, so size it for the longest.
  localparam int MAX_PERIOD = maxOf(maxOf(HOLD_CYCLES, REPEAT_CYCLES),
                                    maxOf(maxOf(RATE0, RATE1), maxOf(RATE2, RATE3)));
  localparam int PW = cntWidth(MAX_PERIOD);

  localparam logic [PW-1:0] HOLD_LAST   = PW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0] REPEAT_LAST = PW'(REPEAT_CYCLES - 1);
  localparam logic [PW-1:0] RATE0_LAST  = PW'(RATE0 - 1);
  localparam logic [PW-1:0] RATE1_LAST  = PW'(RATE1 - 1);
  localparam logic [PW-1:0] RATE2_LAST  = PW'(RATE2 - 1);
  localparam logic [PW-1:0] RATE3_LAST  = PW'(RATE3 - 1);

  logic          keyLevel;
  logic          runSync;
  logic          keyPrev;
  logic          runPrev;
  logic [1:0]    ratePrev;
  logic          keyRise;
  logic          runToggle;
  logic [PW-1:0] rateLast;
  logic [PW-1:0] periodCnt;
  stepState_e    state;

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) uSyncDebounce (
    .clk     (iwClk100M),
    .rst     (iwRst),
    .rawKey  (iwKey),
    .rawRun  (iwRun),
    .keyLevel(keyLevel),
    .runSync (runSync)
  );

  assign owKeyLevel = keyLevel;
  // keyPrev keeps tracking in RUN, so a key held across run->manual is no edge.
  assign keyRise    = keyLevel & ~keyPrev;
  assign runToggle  = runSync ^ runPrev;

  // Terminal count of the run period selected by iwRate.
  always_comb begin
    rateLast = RATE0_LAST;
    case (iwRate)
      2'd0: rateLast = RATE0_LAST;
      2'd1: rateLast = RATE1_LAST;
      2'd2: rateLast = RATE2_LAST;
      2'd3: rateLast = RATE3_LAST;
      default: rateLast = RATE0_LAST;
    endcase
  end

  // One-cycle history of key level, run switch and rate for edge detection.
  always_ff @(posedge iwClk100M) begin
    if (iwRst) begin
      keyPrev  <= 1'b0;
      runPrev  <= 1'b0;
      ratePrev <= 2'd0;
    end else begin
      keyPrev  <= keyLevel;
      runPrev  <= runSync;
      ratePrev <= iwRate;
    end
  end

  // Step FSM: step pulse and step count are registered alongside the state.
  always_ff @(posedge iwClk100M) begin
    if (iwRst) begin
      state       <= IDLE;
      periodCnt   <= '0;
      owStepEn    <= 1'b0;
      owStepCount <= 16'd0;
    end else begin
      owStepEn <= 1'b0;
      if (runToggle) begin
        // Any mode switch parks in IDLE first; never steps on this cycle.
        state     <= IDLE;
        periodCnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            periodCnt <= '0;
            if (runSync) begin
              state <= RUN;
            end else if (keyRise) begin
              state       <= FIRST;
              owStepEn    <= 1'b1;
              owStepCount <= owStepCount + 16'd1;
            end
          end
          FIRST: begin
            // The press step already used one cycle of the hold interval.
            state     <= HOLD;
            periodCnt <= PW'(1);
          end
          HOLD: begin
            if (!keyLevel) begin
              state     <= IDLE;
              periodCnt <= '0;
            end else if (periodCnt == HOLD_LAST) begin
              state       <= REPEAT;
              periodCnt   <= '0;
              owStepEn    <= 1'b1;
              owStepCount <= owStepCount + 16'd1;
            end else begin
              periodCnt <= periodCnt + PW'(1);
            end
          end
          REPEAT: begin
            if (!keyLevel) begin
              state     <= IDLE;
              periodCnt <= '0;
            end else if (periodCnt == REPEAT_LAST) begin
              periodCnt   <= '0;
              owStepEn    <= 1'b1;
              owStepCount <= owStepCount + 16'd1;
            end else begin
              periodCnt <= periodCnt + PW'(1);
            end
          end
          RUN: begin
            if (iwRate != ratePrev) begin
              periodCnt <= '0;
            end else if (periodCnt == rateLast) begin
              periodCnt   <= '0;
              owStepEn    <= 1'b1;
              owStepCount <= owStepCount + 16'd1;
            end else begin
              periodCnt <= periodCnt + PW'(1);
            end
          end
          default: begin
            state     <= IDLE;
            periodCnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_step_controller.sv
// Bench for step_controller with short periods: table-driven phases with
// hand-derived step counts, directed wrap/reset sequences, then random
// stimulus, all compared every cycle against a schedule-based reference.
module tb_step_controller;

  localparam int DEB  = 4;
  localparam int HOLD = 16;
  localparam int REP  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        key;
  logic        run;
  logic [1:0]  rate;
  logic        stepEn;
  logic        keyLevel;
  logic [15:0] stepCount;

  step_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD),
    .REPEAT_CYCLES  (REP),
    .RATE0          (4),
    .RATE1          (8),
    .RATE2          (16),
    .RATE3          (32)
  ) dut (
    .iwClk100M  (clk),
    .iwRst      (rst),
    .iwKey      (key),
    .iwRun      (run),
    .iwRate     (rate),
    .owStepEn   (stepEn),
    .owKeyLevel (keyLevel),
    .owStepCount(stepCount)
  );

  // Clock
  always #5 clk = ~clk;

  // Bookkeeping
  int nChecks = 0;
  int nFail   = 0;
  int cyc     = 0;

  // Reference model: input delay lines, debounce streak, and absolute step schedule.
  typedef enum {M_IDLE, M_HELD, M_RUN} mode_e;
  bit          kq[$];
  bit          rq[$];
  bit          mLevel;
  bit          mLevelPrev;
  bit          mRunPrev;
  bit [1:0]    mRatePrev;
  bit          lastKu;
  int          streak;
  mode_e       mode;
  int          nextStep;
  bit          mStep;
  logic [15:0] mCount;
  logic [15:0] exp_q[$];
  logic        prevDutStep = 1'b0;

  function automatic int rateOf(input logic [1:0] r);
    case (r)
      2'd0: return 4;
      2'd1: return 8;
      2'd2: return 16;
      default: return 32;
    endcase
  endfunction

  task automatic modelReset();
    kq.delete(); kq.push_back(1'b0); kq.push_back(1'b0);
    rq.delete(); rq.push_back(1'b0); rq.push_back(1'b0);
    mLevel = 0; mLevelPrev = 0; mRunPrev = 0; mRatePrev = 2'd0;
    lastKu = 0; streak = 0;
    mode = M_IDLE; nextStep = 0; mStep = 0; mCount = 16'd0;
  endtask

  // Advance the model by one clock edge using the inputs the DUT sampled.
  task automatic modelEdge();
    bit ku;
    bit ru;
    bit rise;
    cyc++;
    mStep = 0;
    if (rst) begin
      modelReset();
      return;
    end
    ku = kq.pop_front(); kq.push_back(key);
    ru = rq.pop_front(); rq.push_back(run);
    rise = mLevel && !mLevelPrev;
    if (ru != mRunPrev) begin
      mode = M_IDLE;
    end else begin
      case (mode)
        M_IDLE: begin
          if (ru) begin
            mode = M_RUN;
            nextStep = cyc + rateOf(rate);
          end else if (rise) begin
            mStep = 1;
            mode = M_HELD;
            nextStep = cyc + HOLD;
          end
        end
        M_HELD: begin
          if (!mLevel) mode = M_IDLE;
          else if (cyc == nextStep) begin
            mStep = 1;
            nextStep = cyc + REP;
          end
        end
        default: begin
          if (rate != mRatePrev) nextStep = cyc + rateOf(rate);
          else if (cyc == nextStep) begin
            mStep = 1;
            nextStep = cyc + rateOf(rate);
          end
        end
      endcase
    end
    mRunPrev   = ru;
    mRatePrev  = rate;
    mLevelPrev = mLevel;
    if (ku == lastKu) streak++;
    else streak = 1;
    lastKu = ku;
    if (ku != mLevel && streak >= DEB) mLevel = ku;
    if (mStep) begin
      mCount = mCount + 16'd1;
      exp_q.push_back(mCount);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Driver: one clock, model update, then compare away from the edge.
  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
    chk("step_en", stepEn, mStep);
    chk("key_level", keyLevel, mLevel);
    chk("step_count", stepCount, mCount);
    chk("no_back_to_back", stepEn & prevDutStep, 1'b0);
    if (stepEn === 1'b1) begin
      chk("sb_step_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) chk("sb_count", stepCount, exp_q.pop_front());
    end
    prevDutStep = stepEn;
  endtask

  task automatic waitStep(input int budget, output int waited);
    bit found;
    waited = 0;
    found  = 0;
    while (!found && waited < budget) begin
      tick();
      waited++;
      if (stepEn === 1'b1) found = 1;
    end
    chk("wait_step_timeout", found, 1'b1);
  endtask

  typedef struct {
    bit       key;
    bit       run;
    bit [1:0] rate;
    int       cycles;
    int       expSteps;
    bit       expLevel;
    int       expCount;
  } row_t;

  row_t rows[16];

  initial begin
    int steps;
    int waited;
    int len;

    // Glitches, debounced press, long hold, run mode with key noise,
    // run->manual with key held, release and re-press.
    rows[0]  = '{1'b1, 1'b0, 2'd0,  3, 0, 1'b0,  0};
    rows[1]  = '{1'b0, 1'b0, 2'd0,  3, 0, 1'b0,  0};
    rows[2]  = '{1'b1, 1'b0, 2'd0,  3, 0, 1'b0,  0};
    rows[3]  = '{1'b0, 1'b0, 2'd0,  3, 0, 1'b0,  0};
    rows[4]  = '{1'b1, 1'b0, 2'd0, 10, 1, 1'b1,  1};
    rows[5]  = '{1'b0, 1'b0, 2'd0, 20, 0, 1'b0,  1};
    rows[6]  = '{1'b1, 1'b0, 2'd0, 64, 7, 1'b1,  8};
    rows[7]  = '{1'b0, 1'b0, 2'd0, 20, 0, 1'b0,  8};
    rows[8]  = '{1'b0, 1'b1, 2'd1, 10, 0, 1'b0,  8};
    rows[9]  = '{1'b1, 1'b1, 2'd1, 12, 2, 1'b1, 10};
    rows[10] = '{1'b0, 1'b1, 2'd1, 12, 1, 1'b0, 11};
    rows[11] = '{1'b1, 1'b1, 2'd1, 10, 2, 1'b1, 13};
    rows[12] = '{1'b1, 1'b0, 2'd1, 20, 0, 1'b1, 13};
    rows[13] = '{1'b0, 1'b0, 2'd1, 10, 0, 1'b0, 13};
    rows[14] = '{1'b1, 1'b0, 2'd1, 10, 1, 1'b1, 14};
    rows[15] = '{1'b0, 1'b0, 2'd1, 20, 0, 1'b0, 14};

    // Reset
    modelReset();
    rst = 1'b1; key = 1'b0; run = 1'b0; rate = 2'd0;
    repeat (3) tick();
    chk("reset_step_en", stepEn, 1'b0);
    chk("reset_key_level", keyLevel, 1'b0);
    chk("reset_step_count", stepCount, 16'd0);
    rst = 1'b0;

    // Table-driven phases
    for (int i = 0; i < 16; i++) begin
      key  = rows[i].key;
      run  = rows[i].run;
      rate = rows[i].rate;
      steps = 0;
      for (int c = 0; c < rows[i].cycles; c++) begin
        tick();
        if (stepEn === 1'b1) steps++;
      end
      chk($sformatf("row%0d_steps", i), steps, rows[i].expSteps);
      chk($sformatf("row%0d_level", i), keyLevel, rows[i].expLevel);
      chk($sformatf("row%0d_count", i), stepCount, rows[i].expCount);
    end

    // Counter wrap: preload near the top, then run at the slowest rate.
    force dut.owStepCount = 16'hFFFC;
    #1;
    release dut.owStepCount;
    mCount = 16'hFFFC;
    run = 1'b1; rate = 2'd3;
    waitStep(60, waited);
    chk("wrap_first_latency", waited, 36);
    chk("wrap_count_fffd", stepCount, 16'hFFFD);
    waitStep(40, waited);
    chk("wrap_gap1", waited, 32);
    chk("wrap_count_fffe", stepCount, 16'hFFFE);
    waitStep(40, waited);
    chk("wrap_gap2", waited, 32);
    chk("wrap_count_ffff", stepCount, 16'hFFFF);
    waitStep(40, waited);
    chk("wrap_gap3", waited, 32);
    chk("wrap_count_0000", stepCount, 16'h0000);

    // Reset in the middle of run mode.
    repeat (10) tick();
    rst = 1'b1;
    tick();
    chk("rst_run_step_en", stepEn, 1'b0);
    chk("rst_run_key_level", keyLevel, 1'b0);
    chk("rst_run_count", stepCount, 16'd0);
    rst = 1'b0;
    steps = 0;
    repeat (32) begin
      tick();
      if (stepEn === 1'b1) steps++;
    end
    chk("rst_run_quiet", steps, 0);

    // Reset while auto-repeating.
    run = 1'b0;
    repeat (10) tick();
    key = 1'b1;
    steps = 0;
    repeat (30) begin
      tick();
      if (stepEn === 1'b1) steps++;
    end
    chk("repeat_steps_before_rst", steps, 2);
    rst = 1'b1; key = 1'b0;
    tick();
    chk("rst_rep_step_en", stepEn, 1'b0);
    chk("rst_rep_key_level", keyLevel, 1'b0);
    chk("rst_rep_count", stepCount, 16'd0);
    rst = 1'b0;
    steps = 0;
    repeat (HOLD) begin
      tick();
      if (stepEn === 1'b1) steps++;
    end
    chk("rst_rep_quiet", steps, 0);

    // Random stimulus against the reference model.
    for (int s = 0; s < 200; s++) begin
      rst = ($urandom_range(0, 39) == 0);
      key = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) run = ~run;
      if ($urandom_range(0, 3) == 0) rate = 2'($urandom_range(0, 3));
      len = rst ? $urandom_range(1, 3) : $urandom_range(1, 40);
      for (int c = 0; c < len; c++) tick();
    end
    rst = 1'b0;
    repeat (5) tick();
    chk("sb_drain", exp_q.size(), 0);

    // Report
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/step_controller.md
STEP_CONTROLLER -- requirements
Module: step_controller

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, stable-input cycles needed before the debounced key changes (10 ms at 100 MHz).
REQ-002 SHALL have parameter HOLD_CYCLES, default 50000000, held-key cycles after the first step before auto-repeat begins.
REQ-003 SHALL have parameter REPEAT_CYCLES, default 10000000, step period during held-key auto-repeat.
REQ-004 SHALL have parameters RATE0..RATE3, defaults 100000000, 10000000, 1000000, 100000, step period in run mode per iwRate value; every period parameter SHALL be >= 2.
REQ-005 SHALL have port iwClk100M, input, 1, the single clock.
REQ-006 SHALL have port iwRst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port iwKey, input, 1, raw asynchronous step push-button.
REQ-008 SHALL have port iwRun, input, 1, asynchronous mode switch: 0 = manual step, 1 = free run.
REQ-009 SHALL have port iwRate, input, 2, run-mode period select.
REQ-010 SHALL have port owStepEn, output, 1, one-cycle step pulse that advances the CPU by one instruction.
REQ-011 SHALL have port owKeyLevel, output, 1, debounced key level.
REQ-012 SHALL have port owStepCount, output, 16, count of issued steps.

Function
REQ-013 SHALL pass iwKey and iwRun each through a 2-flop synchronizer before use; iwRate SHALL be sampled directly (quasi-static).
REQ-014 SHALL change owKeyLevel only after the synchronized key differs from owKeyLevel for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle SHALL clear the debounce counter.
REQ-015 SHALL implement the FSM states IDLE, FIRST, HOLD, REPEAT, RUN.
REQ-016 In IDLE with synchronized run = 0, a 0->1 transition of owKeyLevel SHALL move the FSM to FIRST and assert owStepEn for exactly the next cycle.
REQ-017 In FIRST, the FSM SHALL move to HOLD and start the hold counter.
REQ-018 In HOLD, while owKeyLevel = 1, after HOLD_CYCLES the FSM SHALL move to REPEAT and issue one step.
REQ-019 In REPEAT, the FSM SHALL issue one step every REPEAT_CYCLES while owKeyLevel = 1.
REQ-020 In HOLD or REPEAT, owKeyLevel = 0 SHALL return the FSM to IDLE with no further step.
REQ-021 With synchronized run = 1, the FSM SHALL be in RUN and issue one step every RATEn cycles, n = iwRate, with the first step RATEn cycles after entry; key input SHALL be ignored in RUN.
REQ-022 A change of iwRate in RUN SHALL restart the period counter; the next step SHALL come RATEn cycles after the change.
REQ-023 A synchronized run toggle in any state SHALL force the FSM to IDLE (0->1 then to RUN) with period/hold counters cleared and no step on that cycle.
REQ-024 owStepEn SHALL never be high on two consecutive cycles.
REQ-025 owStepCount SHALL increment by 1 in the same cycle owStepEn is high and SHALL wrap 0xFFFF -> 0x0000.
REQ-026 A key held through a run -> manual toggle SHALL NOT produce a step until it is released and pressed again.

Reset
REQ-027 Reset SHALL clear owStepEn = 0, owKeyLevel = 0, owStepCount = 0, all counters and synchronizers to 0, and set the FSM to IDLE.
REQ-028 Reset asserted mid-hold or mid-run SHALL abort in the same clock edge, and no step SHALL be emitted in the cycle after reset deasserts.

Structure
REQ-029 A shared package ice_risc_dbg_pkg SHALL hold the FSM state enumeration and the default period constants.
REQ-030 The synchronizer and debouncer SHALL be one sub-module, sync_debounce, with a DEBOUNCE_CYCLES parameter.
REQ-031 Counter widths SHALL be derived from the largest relevant parameter via clog2.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=16, REPEAT_CYCLES=8, RATE0..3=4,8,16,32)
REQ-032 Press key with 3-cycle glitches, then hold stable for 10 cycles -> owKeyLevel rises only after 4 stable cycles; exactly one owStepEn; owStepCount = 1.
REQ-033 Hold key 60 cycles after debounce -> first step, then a step 16 cycles later, then steps every 8 cycles; release -> no further steps.
REQ-034 iwRun = 1, iwRate = 2'b01 for 40 cycles after synchronization -> 5 steps spaced exactly 8 cycles apart; key presses during this have no effect.
REQ-035 Preload owStepCount to 0xFFFE via steps in RUN with RATE3, then two more steps -> owStepCount reads 0xFFFF, then 0x0000.
REQ-036 Assert iwRst during REPEAT and during RUN -> all outputs 0 on the next cycle; no step pulse for at least HOLD_CYCLES or RATEn after release.
REQ-037 Toggle iwRun 1 -> 0 while the key is held -> no step until the key is released and re-pressed.
